// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types and constants for the load/store unit slice.
// Rev     : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit_if
// Brief   : Request/response handshake plus word-memory bus of the LSU.
//           Signal names are from the LSU's point of view.
// Rev     : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          i_req_valid;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr;
    logic          i_req_we;
    logic [1:0]    i_req_size;
    logic          i_req_unsigned;
    logic [DW-1:0] i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_fault;
    logic [AW-1:0] o_A;
    logic [DW-1:0] o_WD;
    logic          o_WE;
    logic [DW-1:0] i_RD;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_we, i_req_size, i_req_unsigned,
        input  i_req_wdata, i_rsp_ready, i_RD,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_fault,
        output o_A, o_WD, o_WE
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_we, i_req_size, i_req_unsigned,
        output i_req_wdata, i_rsp_ready, i_RD,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_fault,
        input  o_A, o_WD, o_WE
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Combinational lane select/extend for loads and lane merge for
//           sub-word stores on a little-endian 32-bit word.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  wire logic [DW-1:0] i_word,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [1:0]    i_ofs,
    input  wire logic [1:0]    i_size,
    input  wire logic          i_unsigned,
    output logic      [DW-1:0] o_rdata,
    output logic      [DW-1:0] o_merged
);
    logic [4:0]          w_bsh;
    logic [4:0]          w_hsh;
    logic [LANE_W-1:0]   w_byte;
    logic [2*LANE_W-1:0] w_half;
    logic [DW-1:0]       w_bmask;
    logic [DW-1:0]       w_hmask;

    // Halfword lane uses only ofs[1], so an odd half offset is silently rounded down.
    assign w_bsh   = {i_ofs, 3'b000};
    assign w_hsh   = {i_ofs[1], 4'b0000};
    assign w_byte  = LANE_W'(i_word >> w_bsh);
    assign w_half  = (2*LANE_W)'(i_word >> w_hsh);
    assign w_bmask = DW'({LANE_W{1'b1}}) << w_bsh;
    assign w_hmask = DW'({(2*LANE_W){1'b1}}) << w_hsh;

    always_comb begin
        o_rdata  = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_rdata  = {{(DW-LANE_W){~i_unsigned & w_byte[LANE_W-1]}}, w_byte};
                o_merged = (i_word & ~w_bmask) | (DW'(i_wdata[LANE_W-1:0]) << w_bsh);
            end
            SZ_HALF: begin
                o_rdata  = {{(DW-2*LANE_W){~i_unsigned & w_half[2*LANE_W-1]}}, w_half};
                o_merged = (i_word & ~w_hmask) | (DW'(i_wdata[2*LANE_W-1:0]) << w_hsh);
            end
            default: begin
                o_rdata  = i_word;
                o_merged = i_wdata;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : MEM-stage sequencer: aligned loads, read-modify-write sub-word
//           stores, one request in flight. Option macro: LSU_ALIGN_CHECK_EN
//           (defined = misaligned half/word requests fault).
// Rev     : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    load_store_unit_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_RMW_RD = ST_RMW_RD;
    localparam logic [2:0] S_WRITE  = ST_WRITE;
    localparam logic [2:0] S_RESP   = ST_RESP;

    logic [2:0]    r_state;
    logic [1:0]    r_ofs;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_fault;
    logic [AW-1:0] r_A;
    logic [DW-1:0] r_WD;
    logic          r_WE;

    logic          w_req_fault;
    logic [DW-1:0] w_ld_data;
    logic [DW-1:0] w_merged;

    always_comb begin
        w_req_fault = (bus.i_req_size == SZ_ILLEGAL);
`ifdef LSU_ALIGN_CHECK_EN
        if ((bus.i_req_size == SZ_HALF && bus.i_req_addr[0]) ||
            (bus.i_req_size == SZ_WORD && bus.i_req_addr[1:0] != 2'b00))
            w_req_fault = 1'b1;
`endif
    end

    lsu_lane_align #(.DW(DW)) u_lane_align (
        .i_word     (bus.i_RD),
        .i_wdata    (r_wdata),
        .i_ofs      (r_ofs),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_rdata    (w_ld_data),
        .o_merged   (w_merged)
    );

    // Memory-side outputs are registered on entry to the access state so the
    // address is already stable for the whole cycle the combinational read uses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ofs   <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
            r_A     <= '0;
            r_WD    <= '0;
            r_WE    <= 1'b0;
        end else begin
            r_WE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_req_valid) begin
                        r_ofs   <= bus.i_req_addr[1:0];
                        r_size  <= bus.i_req_size;
                        r_uns   <= bus.i_req_unsigned;
                        r_wdata <= bus.i_req_wdata;
                        r_rdata <= '0;
                        r_fault <= w_req_fault;
                        if (w_req_fault) begin
                            r_state <= S_RESP;
                        end else begin
                            r_A <= {bus.i_req_addr[AW-1:2], 2'b00};
                            if (!bus.i_req_we) begin
                                r_state <= S_LOAD;
                            end else if (bus.i_req_size == SZ_WORD) begin
                                r_WD    <= bus.i_req_wdata;
                                r_WE    <= 1'b1;
                                r_state <= S_WRITE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_ld_data;
                    r_state <= S_RESP;
                end
                S_RMW_RD: begin
                    r_WD    <= w_merged;
                    r_WE    <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_rsp_ready)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready = (r_state == S_IDLE) && !i_rst;
    assign bus.o_rsp_valid = (r_state == S_RESP);
    assign bus.o_rsp_rdata = r_rdata;
    assign bus.o_rsp_fault = r_fault;
    assign bus.o_A         = r_A;
    assign bus.o_WD        = r_WD;
    assign bus.o_WE        = r_WE;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Self-checking bench: directed vector table, reset/stall sequences
//           and random requests against a byte-array reference memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] dut_mem [16384];
    logic [7:0]  ref_mem [65536];

    load_store_unit_if #(.AW(16), .DW(32)) bus ();

    load_store_unit #(.AW(16), .DW(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_RD = dut_mem[bus.o_A[15:2]];
    always @(posedge clk) if (bus.o_WE) dut_mem[bus.o_A[15:2]] <= bus.o_WD;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (little-endian byte memory) ----------
    function automatic logic [15:0] eff_addr(input logic [15:0] a, input logic [1:0] size);
        if (size == 2'd1) return a & 16'hFFFE;
        if (size == 2'd2) return a & 16'hFFFC;
        return a;
    endfunction

    function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] size, input logic uns);
        int unsigned val = 0;
        int nb = 1 << size;
        logic [15:0] ea = eff_addr(a, size);
        for (int i = 0; i < nb; i++) val += int'(ref_mem[ea + 16'(i)]) << (8 * i);
        if (!uns && nb < 4 && val >= (32'd1 << (8 * nb - 1))) val -= (32'd1 << (8 * nb));
        return val;
    endfunction

    task automatic ref_store(input logic [15:0] a, input logic [1:0] size, input logic [31:0] wd);
        logic [15:0] ea = eff_addr(a, size);
        for (int i = 0; i < (1 << size); i++) ref_mem[ea + 16'(i)] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) w |= 32'(ref_mem[(a & 16'hFFFC) + 16'(i)]) << (8 * i);
        return w;
    endfunction

    function automatic logic ref_fault(input logic [15:0] a, input logic [1:0] size);
        logic f = (size == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'd1 && a[0] != 1'b0) f = 1'b1;
        if (size == 2'd2 && (a % 4) != 0) f = 1'b1;
`endif
        return f;
    endfunction

    // ---------------- one complete request/response transaction ------------
    task automatic run_req(input logic [15:0] addr, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input int hold,
                           output logic [31:0] rdata, output logic fault, output int lat,
                           output int we_cnt, output logic [15:0] we_addr, output logic [31:0] we_data);
        int n = 0;
        @(negedge clk);
        bus.i_req_valid    = 1'b1;
        bus.i_req_addr     = addr;
        bus.i_req_we       = we;
        bus.i_req_size     = size;
        bus.i_req_unsigned = uns;
        bus.i_req_wdata    = wdata;
        while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready", 32'(bus.o_req_ready), 32'd1);
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        lat = 0; we_cnt = 0; we_addr = 0; we_data = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.o_WE) begin we_cnt++; we_addr = bus.o_A; we_data = bus.o_WD; end
        end while (!bus.o_rsp_valid && lat < 20);
        check("rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        rdata = bus.o_rsp_rdata;
        fault = bus.o_rsp_fault;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rdata", bus.o_rsp_rdata, rdata);
            check("hold_valid", 32'(bus.o_rsp_valid), 32'd1);
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 1'b0;
    endtask

    vec_t        vecs [18];
    int          nv;
    logic [31:0] rd, wd_seen, saved, exp;
    logic [15:0] wa_seen;
    logic        flt;
    int          lat, wec;

    initial begin
        checks = 0; errors = 0; nv = 0;
        rst = 1'b1;
        bus.i_req_valid = 0; bus.i_req_addr = 0; bus.i_req_we = 0; bus.i_req_size = 0;
        bus.i_req_unsigned = 0; bus.i_req_wdata = 0; bus.i_rsp_ready = 0;
        for (int i = 0; i < 16384; i++) begin
            logic [31:0] w = $urandom;
            dut_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[i * 4 + b] = 8'(w >> (8 * b));
        end

        // ---- reset values ----
        @(negedge clk);
        check("rst_req_ready", 32'(bus.o_req_ready), 0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("rst_rdata", bus.o_rsp_rdata, 0);
        check("rst_fault", 32'(bus.o_rsp_fault), 0);
        check("rst_A", 32'(bus.o_A), 0);
        check("rst_WD", bus.o_WD, 0);
        check("rst_WE", 32'(bus.o_WE), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.o_req_ready), 1);

        // ---- reset during RMW_RD: the write must never happen ----
        saved = dut_mem[16'h0010 >> 2];
        bus.i_req_valid = 1; bus.i_req_addr = 16'h0011; bus.i_req_we = 1;
        bus.i_req_size = SZ_BYTE; bus.i_req_unsigned = 0; bus.i_req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.i_req_valid = 0;
        @(negedge clk);
        check("rmw_rd_WE", 32'(bus.o_WE), 0);
        check("rmw_rd_A", 32'(bus.o_A), 32'h0010);
        rst = 1'b1;
        #1;
        check("async_rst_A", 32'(bus.o_A), 0);
        check("async_rst_ready", 32'(bus.o_req_ready), 0);
        wec = 0;
        repeat (2) begin @(negedge clk); if (bus.o_WE) wec++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.o_WE) wec++; end
        check("rmw_rst_we_count", 32'(wec), 0);
        check("rmw_rst_ready", 32'(bus.o_req_ready), 1);
        check("rmw_rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("rmw_rst_mem", dut_mem[16'h0010 >> 2], saved);

        // ---- directed vector table ----
        vecs[nv++] = '{16'h0010, 1, 2'd2, 0, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF};
        vecs[nv++] = '{16'h0010, 0, 2'd2, 0, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0013, 0, 2'd0, 0, 32'h0,        32'hFFFFFFDE, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0013, 0, 2'd0, 1, 32'h0,        32'h000000DE, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0010, 0, 2'd1, 0, 32'h0,        32'hFFFFBEEF, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0012, 0, 2'd1, 1, 32'h0,        32'h0000DEAD, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0011, 1, 2'd0, 0, 32'h00000012, 32'h0,        0, 3, 1, 32'hDEAD12EF};
        vecs[nv++] = '{16'h0012, 1, 2'd1, 0, 32'h0000CAFE, 32'h0,        0, 3, 1, 32'hCAFE12EF};
        vecs[nv++] = '{16'h0010, 0, 2'd2, 0, 32'h0,        32'hCAFE12EF, 0, 2, 0, 32'h0};
`ifdef LSU_ALIGN_CHECK_EN
        vecs[nv++] = '{16'h0012, 0, 2'd2, 0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
`else
        vecs[nv++] = '{16'h0012, 0, 2'd2, 0, 32'h0,        32'hCAFE12EF, 0, 2, 0, 32'h0};
`endif
        vecs[nv++] = '{16'h0010, 0, 2'd3, 0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
        vecs[nv++] = '{16'h0010, 1, 2'd3, 0, 32'h12345678, 32'h0,        1, 1, 0, 32'h0};
        vecs[nv++] = '{16'h0010, 0, 2'd0, 0, 32'h0,        32'hFFFFFFEF, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'h0010, 0, 2'd1, 1, 32'h0,        32'h000012EF, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'hFFFC, 1, 2'd2, 0, 32'h11223344, 32'h0,        0, 2, 1, 32'h11223344};
        vecs[nv++] = '{16'hFFFC, 0, 2'd2, 0, 32'h0,        32'h11223344, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'hFFFF, 0, 2'd0, 0, 32'h0,        32'h00000011, 0, 2, 0, 32'h0};
        vecs[nv++] = '{16'hFFFE, 0, 2'd1, 0, 32'h0,        32'h00001122, 0, 2, 0, 32'h0};

        for (int i = 0; i < nv; i++) begin
            run_req(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0,
                    rd, flt, lat, wec, wa_seen, wd_seen);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_pulses", i), 32'(wec), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we != 0) begin
                check($sformatf("vec%0d_WD", i), wd_seen, vecs[i].exp_wd);
                check($sformatf("vec%0d_A", i), 32'(wa_seen), 32'(vecs[i].addr & 16'hFFFC));
                ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
            end
        end

        // ---- response stall with a competing request pending ----
        @(negedge clk);
        bus.i_req_valid = 1; bus.i_req_addr = 16'h0010; bus.i_req_we = 0;
        bus.i_req_size = SZ_WORD; bus.i_req_unsigned = 0;
        @(posedge clk);
        #1 bus.i_req_addr = 16'h0013; bus.i_req_size = SZ_BYTE; bus.i_req_unsigned = 1;
        repeat (2) @(negedge clk);
        check("stall_first_valid", 32'(bus.o_rsp_valid), 1);
        check("stall_first_rdata", bus.o_rsp_rdata, ref_load(16'h0010, 2'd2, 0));
        rd = bus.o_rsp_rdata;
        wec = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.o_rsp_valid || bus.o_rsp_rdata !== rd || bus.o_req_ready) wec++;
        end
        check("stall_stable_violations", 32'(wec), 0);
        bus.i_rsp_ready = 1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 0;
        @(negedge clk);
        check("post_hs_ready", 32'(bus.o_req_ready), 1);
        check("post_hs_valid", 32'(bus.o_rsp_valid), 0);
        @(posedge clk);
        #1 bus.i_req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.o_rsp_valid && lat < 20);
        check("second_latency", 32'(lat), 2);
        check("second_rdata", bus.o_rsp_rdata, ref_load(16'h0013, 2'd0, 1));
        bus.i_rsp_ready = 1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 0;

        // ---- random traffic against the reference model ----
        for (int k = 0; k < 400; k++) begin
            logic [15:0] a;
            logic        w, u, ef;
            logic [1:0]  s;
            logic [31:0] d;
            int          el;
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63)) : 16'hFFC0 + 16'($urandom_range(0, 63));
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            d = $urandom;
            ef = ref_fault(a, s);
            el = ef ? 1 : (!w || s == 2'd2) ? 2 : 3;
            run_req(a, w, s, u, d, $urandom_range(0, 2), rd, flt, lat, wec, wa_seen, wd_seen);
            check("rnd_fault", 32'(flt), 32'(ef));
            check("rnd_latency", 32'(lat), 32'(el));
            check("rnd_we_pulses", 32'(wec), (w && !ef) ? 1 : 0);
            if (ef || w) exp = 0; else exp = ref_load(a, s, u);
            check("rnd_rdata", rd, exp);
            if (w && !ef) begin
                ref_store(a, s, d);
                check("rnd_A", 32'(wa_seen), 32'(a & 16'hFFFC));
                check("rnd_WD", wd_seen, ref_word(a));
                check("rnd_mem", dut_mem[a >> 2], ref_word(a));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
